// File: rtl/bsg_rr_pkg.sv
// ============================================================================
// bsg_rr_pkg : shared types/helpers for the round-robin packet concentrator
// Revision   : 1.0
// ============================================================================
`default_nettype none

`ifndef BSG_RR_ENTRY_T
`define BSG_RR_ENTRY_T(dw, tw) struct packed { logic [(dw)-1:0] data; logic [(tw)-1:0] tag; logic last; }
`endif

package bsg_rr_pkg;

    localparam int BSG_RR_BUF_ENTRIES = 2;

    // Fold an index from the doubled request vector back onto a channel number.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_rr_out_buf.sv
// ============================================================================
// bsg_rr_out_buf : two-entry FIFO, valid/ready output, full from registers only
// Revision       : 1.0
// ============================================================================
`default_nettype none

module bsg_rr_out_buf
    import bsg_rr_pkg::*;
#(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               full_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
);

    logic [width_p-1:0] mem_r [BSG_RR_BUF_ENTRIES];
    logic               wr_ptr_r;
    logic               rd_ptr_r;
    logic [1:0]         count_r;
    logic               enq;
    logic               deq;

    assign full_o = (count_r == 2'(BSG_RR_BUF_ENTRIES));
    assign v_o    = (count_r != 2'd0);
    assign data_o = mem_r[rd_ptr_r];
    assign enq    = v_i & ~full_o;
    assign deq    = v_o & ready_i;

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (enq) wr_ptr_r <= ~wr_ptr_r;
            if (deq) rd_ptr_r <= ~rd_ptr_r;
            case ({enq, deq})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/bsg_round_robin_n_to_1_pkt.sv
// ============================================================================
// bsg_round_robin_n_to_1_pkt : N-to-1 round-robin concentrator, packet lock
// Revision                   : 1.0
// ============================================================================
`default_nettype none

module bsg_round_robin_n_to_1_pkt
    import bsg_rr_pkg::*;
#(
    parameter int width_p        = 16,
    parameter int num_in_p       = 4,
    parameter int lock_on_last_p = 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [num_in_p-1:0]           v_i,
    input  logic [num_in_p*width_p-1:0]   data_i,
    input  logic [num_in_p-1:0]           last_i,
    output logic [num_in_p-1:0]           yumi_o,
    output logic                          v_o,
    output logic [width_p-1:0]            data_o,
    output logic [$clog2(num_in_p)-1:0]   tag_o,
    output logic                          last_o,
    input  logic                          ready_i
);

    localparam int tag_width_lp = $clog2(num_in_p);
    localparam logic [num_in_p-1:0] one_lp = num_in_p'(1);

    typedef `BSG_RR_ENTRY_T(width_p, tag_width_lp) entry_t;

    logic [tag_width_lp-1:0]  last_r;
    logic [tag_width_lp-1:0]  lock_tag_r;
    logic                     lock_r;
    logic [num_in_p-1:0]      eligible;
    logic [2*num_in_p-1:0]    req2;
    logic [tag_width_lp-1:0]  grant;
    logic                     any_grant;
    logic                     full;
    logic                     enq;
    entry_t                   enq_entry;
    entry_t                   head_entry;

    always_comb begin
        eligible = v_i;
        if (lock_r) begin
            eligible = v_i & (one_lp << lock_tag_r);
        end
    end

    // Window [last_r+1, last_r+num_in_p] of the doubled vector is the rotated
    // request list; descending scan leaves the lowest hit in grant.
    assign req2 = {eligible, eligible};

    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        for (int j = 2*num_in_p-1; j >= 0; j--) begin
            if (req2[j] && (j > int'(last_r)) && (j <= int'(last_r) + num_in_p)) begin
                grant     = tag_width_lp'(rr_wrap(j, num_in_p));
                any_grant = 1'b1;
            end
        end
    end

    assign enq    = any_grant & ~full & ~reset_i;
    assign yumi_o = enq ? (one_lp << grant) : '0;

    always_comb begin
        enq_entry.data = data_i[int'(grant)*width_p +: width_p];
        enq_entry.tag  = grant;
        enq_entry.last = last_i[grant];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_r     <= tag_width_lp'(num_in_p-1);
            lock_r     <= 1'b0;
            lock_tag_r <= '0;
        end else if (enq) begin
            last_r <= grant;
            if (last_i[grant]) begin
                lock_r <= 1'b0;
            end else if (lock_on_last_p != 0) begin
                lock_r     <= 1'b1;
                lock_tag_r <= grant;
            end
        end
    end

    bsg_rr_out_buf #(
        .width_p ($bits(entry_t))
    ) u_out_buf (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (enq),
        .data_i  (enq_entry),
        .full_o  (full),
        .v_o     (v_o),
        .data_o  (head_entry),
        .ready_i (ready_i)
    );

    assign data_o = head_entry.data;
    assign tag_o  = head_entry.tag;
    assign last_o = head_entry.last;

endmodule

`default_nettype wire

// File: tb/tb_bsg_round_robin_n_to_1_pkt.sv
// ============================================================================
// tb_bsg_round_robin_n_to_1_pkt : directed bench for the round-robin concentrator
// Revision                      : 1.0
// ============================================================================
`default_nettype none

module tb_bsg_round_robin_n_to_1_pkt;

    logic        clk = 1'b0;
    logic        rst;

    // Four-channel pair (A: packet lock on, B: lock off) share stimulus.
    logic [3:0]  v4, last4;
    logic [63:0] data4;
    logic        ready4;
    logic [3:0]  yumi_a, yumi_b;
    logic        vo_a, vo_b, lo_a, lo_b;
    logic [15:0] do_a, do_b;
    logic [1:0]  tag_a, tag_b;

    // Three-channel instance C.
    logic [2:0]  v3, last3, yumi_c;
    logic [47:0] data3;
    logic        ready3, vo_c, lo_c;
    logic [15:0] do_c;
    logic [1:0]  tag_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bsg_round_robin_n_to_1_pkt #(.width_p(16), .num_in_p(4), .lock_on_last_p(1)) dut_a (
        .clk_i(clk), .reset_i(rst), .v_i(v4), .data_i(data4), .last_i(last4),
        .yumi_o(yumi_a), .v_o(vo_a), .data_o(do_a), .tag_o(tag_a), .last_o(lo_a),
        .ready_i(ready4));

    bsg_round_robin_n_to_1_pkt #(.width_p(16), .num_in_p(4), .lock_on_last_p(0)) dut_b (
        .clk_i(clk), .reset_i(rst), .v_i(v4), .data_i(data4), .last_i(last4),
        .yumi_o(yumi_b), .v_o(vo_b), .data_o(do_b), .tag_o(tag_b), .last_o(lo_b),
        .ready_i(ready4));

    bsg_round_robin_n_to_1_pkt #(.width_p(16), .num_in_p(3), .lock_on_last_p(1)) dut_c (
        .clk_i(clk), .reset_i(rst), .v_i(v3), .data_i(data3), .last_i(last3),
        .yumi_o(yumi_c), .v_o(vo_c), .data_o(do_c), .tag_o(tag_c), .last_o(lo_c),
        .ready_i(ready3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] t1_yumi  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [1:0] t1_tag   [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [2:0] c_yumi   [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        logic [1:0] c_tag    [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        logic [3:0] lk_v     [7] = '{4'b0100, 4'b1111, 4'b1011, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
        logic [3:0] lk_last  [7] = '{4'b1011, 4'b1011, 4'b1011, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
        logic [3:0] lk_ya    [7] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
        logic [3:0] lk_yb    [7] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000};
        logic [1:0] exp_ta   [4] = '{2'd2, 2'd2, 2'd2, 2'd3};
        logic [1:0] exp_tb   [5] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        logic [3:0] bp_yumi  [8] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] bp_tag   [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [1:0] qa [$];
        logic [1:0] qb [$];

        rst    = 1'b1;
        v4     = 4'b1111;
        last4  = 4'b1111;
        data4  = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        ready4 = 1'b1;
        v3     = 3'b111;
        last3  = 3'b111;
        data3  = {16'hC002, 16'hC001, 16'hC000};
        ready3 = 1'b1;

        // Reset state with every channel requesting.
        repeat (2) @(negedge clk);
        #1;
        check("rst_vo_a",   32'(vo_a),   32'd0);
        check("rst_yumi_a", 32'(yumi_a), 32'd0);
        check("rst_yumi_b", 32'(yumi_b), 32'd0);
        check("rst_vo_c",   32'(vo_c),   32'd0);
        check("rst_yumi_c", 32'(yumi_c), 32'd0);

        // Fair rotation on four and three channels.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_yumi_a", 32'(yumi_a), 32'(t1_yumi[i]));
            check("rr_yumi_c", 32'(yumi_c), 32'(c_yumi[i]));
            if (i > 0) begin
                check("rr_vo_a",   32'(vo_a),  32'd1);
                check("rr_tag_a",  32'(tag_a), 32'(t1_tag[i]));
                check("rr_data_a", 32'(do_a),  32'(16'hD000 + 16'(t1_tag[i])));
                check("rr_tag_c",  32'(tag_c), 32'(c_tag[i]));
                check("rr_tagmax_c", 32'(tag_c < 2'd3), 32'd1);
                check("rr_data_c", 32'(do_c),  32'(16'hC000 + 16'(c_tag[i])));
            end else begin
                check("rr_vo0_a", 32'(vo_a), 32'd0);
            end
            @(negedge clk);
        end

        // Packet lock (A) versus per-beat arbitration (B), shared stimulus.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            v4    = lk_v[i];
            last4 = lk_last[i];
            #1;
            check("lk_yumi_a", 32'(yumi_a), 32'(lk_ya[i]));
            check("lk_yumi_b", 32'(yumi_b), 32'(lk_yb[i]));
            if (vo_a) qa.push_back(tag_a);
            if (vo_b) qb.push_back(tag_b);
            @(negedge clk);
        end
        check("lk_cnt_a", 32'(qa.size()), 32'd4);
        check("lk_cnt_b", 32'(qb.size()), 32'd5);
        for (int i = 0; i < 4; i++) if (i < qa.size()) check("lk_seq_a", 32'(qa[i]), 32'(exp_ta[i]));
        for (int i = 0; i < 5; i++) if (i < qb.size()) check("lk_seq_b", 32'(qb[i]), 32'(exp_tb[i]));

        // Backpressure: two beats accepted, then stall until space frees.
        do_reset();
        qa.delete();
        v4     = 4'b1111;
        last4  = 4'b1111;
        ready4 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) ready4 = 1'b1;
            #1;
            check("bp_yumi_a", 32'(yumi_a), 32'(bp_yumi[i]));
            if (i >= 1 && i < 4) check("bp_hold_tag_a", 32'(tag_a), 32'd0);
            if (vo_a && ready4) begin
                qa.push_back(tag_a);
                check("bp_data_a", 32'(do_a), 32'(16'hD000 + 16'(tag_a)));
            end
            @(negedge clk);
        end
        check("bp_cnt_a", 32'(qa.size()), 32'd4);
        for (int i = 0; i < 4; i++) if (i < qa.size()) check("bp_seq_a", 32'(qa[i]), 32'(bp_tag[i]));

        // Asynchronous reset mid-packet with the buffer full.
        do_reset();
        v4     = 4'b0100;
        last4  = 4'b0000;
        ready4 = 1'b0;
        #1;
        check("ar_yumi0_a", 32'(yumi_a), 32'b0100);
        @(negedge clk);
        #1;
        check("ar_yumi1_a", 32'(yumi_a), 32'b0100);
        @(negedge clk);
        #1;
        check("ar_full_yumi_a", 32'(yumi_a), 32'd0);
        check("ar_full_vo_a",   32'(vo_a),   32'd1);
        check("ar_full_last_a", 32'(lo_a),   32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("ar_vo_drop_a",  32'(vo_a),   32'd0);
        check("ar_yumi_rst_a", 32'(yumi_a), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        v4     = 4'b1111;
        last4  = 4'b1111;
        ready4 = 1'b1;
        #1;
        check("ar_first_yumi_a", 32'(yumi_a), 32'b0001);
        check("ar_vo_post_a",    32'(vo_a),   32'd0);
        @(negedge clk);
        #1;
        check("ar_first_tag_a", 32'(tag_a), 32'd0);
        check("ar_first_vo_a",  32'(vo_a),  32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bsg_round_robin_n_to_1_pkt.md
# bsg_round_robin_n_to_1_pkt

Parametrised successor to the two-input round-robin concentrator. It merges `num_in_p` valid/yumi input channels of `width_p`-bit data onto one output. Grants rotate fairly between channels, and an optional packet lock holds a grant until the packet's last beat has been sent. A two-entry output buffer with a valid/ready interface breaks the combinational path from the downstream consumer back to the producers. The block sits between network-side producers (router ports, DMA engines) and a single shared consumer.

## Interface
- `width_p`, default 16: data width per channel.
- `num_in_p`, default 4: number of input channels, at least 2.
- `lock_on_last_p`, default 1: 1 holds the grant until a beat with `last_i`=1 transfers; 0 arbitrates every beat.
- `tag_width_lp`, default `$clog2(num_in_p)`: width of `tag_o`; derived, not overridable.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `v_i`  in  `num_in_p`  per-channel valid.
- `data_i`  in  `num_in_p*width_p`  channel k occupies bits `[k*width_p +: width_p]`.
- `last_i`  in  `num_in_p`  per-channel end-of-packet flag.
- `yumi_o`  out  `num_in_p`  one-hot dequeue; the beat of channel k is consumed this cycle.
- `v_o`  out  1  output buffer head valid.
- `data_o`  out  `width_p`  head data.
- `tag_o`  out  `tag_width_lp`  source channel of head.
- `last_o`  out  1  head end-of-packet flag.
- `ready_i`  in  1  consumer accepts the head when `v_o & ready_i`.

## Operation
- State:
  - `last_r`: the last granted channel.
  - `lock_r`: 1 bit.
  - `lock_tag_r`: the locked channel.
  - Output buffer: 2 entries of {data, tag, last}.
- Enqueue permitted when the buffer is not full. Full is computed from registered occupancy only, so `ready_i` has no combinational path to `yumi_o`.
- Unlocked arbitration: search channels `last_r+1`, `last_r+2`, …, wrapping modulo `num_in_p`. Grant the first channel with `v_i` high. `yumi_o[g]` = any valid & not full.
- Locked arbitration (`lock_r`=1): only `lock_tag_r` is eligible. If that channel's `v_i` is low, no grant is made, even if other channels are valid.
- On a yumi of channel g:
  - `last_r` ← g.
  - If `lock_on_last_p` and `last_i[g]`=0, then `lock_r` ← 1 and `lock_tag_r` ← g.
  - If `last_i[g]`=1, then `lock_r` ← 0.
- `last_r` does not change on cycles with no yumi.
- `yumi_o` is at most one-hot, is always a subset of `v_i`, and is 0 while full.
- Buffer is first in, first out. A simultaneous enqueue and dequeue with occupancy 1 or 2 leaves occupancy unchanged.
- Non-power-of-two `num_in_p`: `tag_o` never exceeds `num_in_p-1`, and the wrap from `num_in_p-1` returns to 0.

## Timing
- Reset values, applied asynchronously:
  - `last_r` = `num_in_p-1`, so channel 0 has first priority.
  - `lock_r` = 0, `lock_tag_r` = 0, occupancy = 0.
  - `v_o`=0. `data_o`, `tag_o` and `last_o` are don't-care.
  - `yumi_o`=0 while `reset_i` is high.
- Latency: a beat taken by `yumi_o` in cycle n appears at `v_o` in cycle n+1 if the buffer was empty.
- Throughput: 1 beat/cycle with `ready_i` held high. After `ready_i` drops, at most 2 more beats are accepted, then `yumi_o`=0 until space frees.
- Reset mid-packet clears the lock and flushes buffered beats; no partial packet is emitted after reset.
- `v_i`/`data_i` are sampled only in the yumi cycle. A producer may not retract `v_i` without a yumi; the block does not check this.

## Structure
- Shared package `bsg_rr_pkg`: typedef for the buffer entry struct {data, tag, last}, parametrised via a macro on `width_p`/`tag_width_lp`.
- Sub-module `bsg_rr_out_buf`: the 2-entry valid/ready buffer, reusable elsewhere.
- Arbiter and lock logic are inline in the top module; the rotation uses a double-width priority encode.

## Test plan
- Reset, then `num_in_p`=4 with all `v_i`=1111, `last_i`=1111, `ready_i`=1 → `tag_o` sequence 0,1,2,3,0 starting one cycle after reset release; one `yumi_o` bit per cycle.
- Lock: channel 2 sends a 3-beat packet (`last_i` 0,0,1) while channels 0/1/3 are valid; channel 2 idles one cycle mid-packet → no yumi that cycle; output tags 2,2,2 contiguous, then 3.
- Backpressure: `ready_i`=0 with all channels valid → exactly 2 yumis, then `yumi_o`=0. Raise `ready_i` → data is in order and no beat is lost or duplicated.
- `lock_on_last_p`=0 with the same packet stimulus as the lock test → tags interleave 2,3,0,1,2.
- `num_in_p`=3: wrap from 2 to 0, and `tag_o` is never 3.
- Assert `reset_i` asynchronously mid-packet with 2 entries buffered → `v_o` drops immediately and the lock clears. After release, channel 0 is granted first.
